cmp16_rr_sched: RTL
===================

CMP16_RR_SCHED -- requirements
Module: cmp16_rr_sched

Interface
REQ-001 SHALL have parameter DW, default 16, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  4  per-requester compare request.
REQ-005 SHALL have port req_a  input  4*DW  operand A; requester i in bits [i*DW +: DW].
REQ-006 SHALL have port req_b  input  4*DW  operand B; same packing as req_a.
REQ-007 SHALL have port req_ready  output  4  one-hot grant; request i accepted when req_valid[i] and req_ready[i] are both high on a clock edge.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  2  index of the requester that owns the result.
REQ-011 SHALL have ports rsp_eq, rsp_gt, rsp_lt  output  1 each  registered compare flags; exactly one is high while rsp_valid is high.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL share one DW-bit comparator (eq/gt/lt) among 4 requesters through a 3-state FSM: IDLE, CMP, RESP.
REQ-014 IDLE: if no req_valid bit is high, the FSM SHALL stay in IDLE with req_ready=0.
REQ-015 IDLE: if any req_valid bit is high, the FSM SHALL grant the first valid requester at or after rr_ptr, wrapping modulo 4, and SHALL drive only that req_ready bit high, combinationally in the same cycle.
REQ-016 At acceptance the FSM SHALL capture a, b and the granted id into registers, then go to CMP.
REQ-017 CMP: the FSM SHALL load rsp_eq/gt/lt from the captured operands, set rsp_valid=1 and go to RESP.
REQ-018 RESP: the FSM SHALL hold rsp_valid and all rsp_* signals stable until rsp_ready=1, then clear rsp_valid and return to IDLE.
REQ-019 On that RESP exit, rr_ptr SHALL become (rsp_id+1) mod 4.
REQ-020 rsp_ready=1 in the same cycle rsp_valid first rises SHALL complete the handshake on that edge.
REQ-021 Latency SHALL be 2 edges from acceptance to rsp_valid. Minimum issue interval SHALL be 3 cycles.
REQ-022 req_ready SHALL be 0 in CMP and RESP. Requests arriving there SHALL wait and SHALL NOT be lost or reordered.
REQ-023 A requester that drops req_valid before being granted SHALL simply not be served; no state change.
REQ-024 rsp_ready outside RESP SHALL be ignored.
REQ-025 Captured operands SHALL be immune to req_a/req_b changes after acceptance.

Reset
REQ-026 While rst_n=0, regardless of clk: FSM=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_eq=rsp_gt=rsp_lt=0, busy=0, req_ready=0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight compare; no response is issued after release.
REQ-028 The first edge after reset release SHALL be able to accept a request.

Configuration
REQ-029 Macro CMP_SIGNED_EN defined: operands SHALL be compared as two's-complement signed.
REQ-030 CMP_SIGNED_EN undefined: operands SHALL be compared as unsigned. eq SHALL be identical in both modes.

Verification
REQ-031 Single request: req_valid=4'b0001, a=16'h1234, b=16'h1234, rsp_ready=1 -> grant on the first edge; 2 edges later rsp_valid=1, rsp_id=0, eq=1, gt=0, lt=0.
REQ-032 Unsigned compare: requester 2, a=16'hFFFF, b=16'h0001 -> rsp_id=2, gt=1. With CMP_SIGNED_EN defined -> lt=1.
REQ-033 Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, one response every 3 cycles.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP, a=16'h0001, b=16'hFFFF -> rsp_valid, rsp_id, lt=1 stable all 5 cycles; req_ready=0; single response after rsp_ready=1.
REQ-035 Reset mid-op: assert rst_n=0 in CMP -> all outputs 0 immediately; after release, no stale response; the next request from requester 0 is served first.
REQ-036 Drop before grant: requester 1 pulses req_valid for 1 cycle while busy -> never granted; no response with rsp_id=1.

Source files
------------

// File: rtl/cmp16_rr_sched.sv
// Four-requester round-robin front end sharing a single DW-bit eq/gt/lt comparator.
// Define CMP_SIGNED_EN to compare operands as two's-complement signed values.
module cmp16_rr_sched #(
   parameter int unsigned DW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req_valid,
   input  logic [4*DW-1:0] req_a,
   input  logic [4*DW-1:0] req_b,
   output logic [3:0]      req_ready,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [1:0]      rsp_id,
   output logic            rsp_eq,
   output logic            rsp_gt,
   output logic            rsp_lt,
   output logic            busy
);

   typedef enum logic [1:0] {StIdle, StCmp, StResp} state_e;

   state_e        state_q;
   logic [1:0]    rr_ptr_q;
   logic [1:0]    id_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic          rsp_valid_q;
   logic [1:0]    rsp_id_q;
   logic          eq_q;
   logic          gt_q;
   logic          lt_q;

   logic          grant_any;
   logic [1:0]    grant_id;
   logic [1:0]    cand;
   logic [3:0]    grant_oh;
   logic [DW-1:0] sel_a;
   logic [DW-1:0] sel_b;
   logic          cmp_eq;
   logic          cmp_gt;
   logic          cmp_lt;

   // First valid requester at or after rr_ptr, wrapping modulo 4.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = rr_ptr_q;
      cand      = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = rr_ptr_q + 2'(k);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
   end

   always_comb begin
      grant_oh = 4'b0000;
      if (grant_any) begin
         grant_oh[grant_id] = 1'b1;
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < 4; i++) begin
         if (grant_id == 2'(i)) begin
            sel_a = req_a[i*DW +: DW];
            sel_b = req_b[i*DW +: DW];
         end
      end
   end

   always_comb begin
      cmp_eq = (a_q == b_q);
`ifdef CMP_SIGNED_EN
      cmp_gt = ($signed(a_q) > $signed(b_q));
`else
      cmp_gt = (a_q > b_q);
`endif
      cmp_lt = !cmp_eq && !cmp_gt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_ptr_q    <= 2'd0;
         id_q        <= 2'd0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 2'd0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (grant_any) begin
                  a_q     <= sel_a;
                  b_q     <= sel_b;
                  id_q    <= grant_id;
                  state_q <= StCmp;
               end
            end
            StCmp: begin
               eq_q        <= cmp_eq;
               gt_q        <= cmp_gt;
               lt_q        <= cmp_lt;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rr_ptr_q    <= rsp_id_q + 2'd1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   // Gate with rst_n so the grant is low during reset even with requests pending.
   assign req_ready = (rst_n && (state_q == StIdle)) ? grant_oh : 4'b0000;
   assign busy      = (state_q != StIdle);
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_eq    = eq_q;
   assign rsp_gt    = gt_q;
   assign rsp_lt    = lt_q;

endmodule
